// File: rtl/k2red_shift_mul.sv
`default_nettype none
// ============================================================================
//  Module      : k2red_shift_mul
//  Description : Iterative digit-serial unsigned multiplier. Retires D
//                multiplier bits per cycle using shift/add only, producing
//                the 2W-bit product that feeds the K2-RED shift reducer.
//                Valid/ready handshake on both sides, sideband tag carried
//                alongside each operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module k2red_shift_mul #(
    parameter int W    = 32,
    parameter int D    = 4,
    parameter int TAGW = 4
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      X,
    input  logic [W-1:0]      Y,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    P,
    output logic [TAGW-1:0]   out_tag
);

    localparam int c_steps = W / D;
    localparam int c_cntw  = (c_steps > 1) ? $clog2(c_steps) : 1;
    localparam logic [c_cntw-1:0] c_cnt_last = c_cntw'(c_steps - 1);
    localparam logic [c_cntw-1:0] c_cnt_one  = c_cntw'(1);

    // Digit size must split the multiplier evenly into whole steps.
    if ((W % D) != 0) begin : g_bad_digit
        $error("k2red_shift_mul: D must divide W");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [W-1:0]        r_mcand;
    logic [W-1:0]        r_mplier;
    logic [W-1:0]        r_acc_hi;
    logic [W-1:0]        r_lo;
    logic [TAGW-1:0]     r_tag;
    logic [c_cntw-1:0]   r_cnt;

    logic [W+D-1:0]      w_pp;
    logic [W+D-1:0]      w_sum;
    logic [W-1:0]        w_acc_hi_nxt;
    logic [W-1:0]        w_lo_nxt;
    logic                w_accept;
    logic                w_last;

    // Ready when idle, or when the held result is leaving on this same edge.
    assign in_ready = rst & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_state == S_MUL) && (r_cnt == c_cnt_last);

    // Partial product of the multiplicand with the low multiplier digit,
    // formed as a sum of shifted multiplicand copies.
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < D; i++) begin
            if (r_mplier[i]) begin
                w_pp = w_pp + ({{D{1'b0}}, r_mcand} << i);
            end
        end
    end

    // Accumulate and shift one digit. acc_hi < 2^W and pp <= (2^W-1)(2^D-1),
    // so the sum is bounded by (2^W-1)*2^D and fits W+D bits exactly.
    always_comb begin
        w_sum        = {{D{1'b0}}, r_acc_hi} + w_pp;
        w_acc_hi_nxt = w_sum[W+D-1:D];
        w_lo_nxt     = W'({w_sum[D-1:0], r_lo} >> D);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a finished result in DONE can hand straight over to
    // a new operation when both handshakes fire on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = in_valid ? S_MUL : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, per-digit accumulation and result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc_hi  <= '0;
            r_lo      <= '0;
            r_tag     <= '0;
            r_cnt     <= '0;
            P         <= '0;
            out_tag   <= '0;
            out_valid <= 1'b0;
        end else begin
            if ((r_state == S_DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_mcand  <= X;
                r_mplier <= Y;
                r_tag    <= in_tag;
                r_acc_hi <= '0;
                r_lo     <= '0;
                r_cnt    <= '0;
            end else if (r_state == S_MUL) begin
                r_acc_hi <= w_acc_hi_nxt;
                r_lo     <= w_lo_nxt;
                r_mplier <= r_mplier >> D;
                r_cnt    <= r_cnt + c_cnt_one;
                if (w_last) begin
                    P         <= {w_acc_hi_nxt, w_lo_nxt};
                    out_tag   <= r_tag;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_k2red_shift_mul.sv
`default_nettype none
// ============================================================================
//  Module      : tb_k2red_shift_mul
//  Description : Directed self-checking bench for k2red_shift_mul.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_k2red_shift_mul;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  X;
    logic [31:0]  Y;
    logic [3:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  P;
    logic [3:0]   out_tag;

    int           n_assert;
    int           n_fail;
    int           lat;
    logic [31:0]  rx;
    logic [31:0]  ry;
    logic [63:0]  exp_p;
    logic [3:0]   exp_tag;

    k2red_shift_mul #(.W(32), .D(4), .TAGW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present an operation, wait (bounded) for in_ready, and clock it in.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t);
        int n;
        X = x; Y = y; in_tag = t; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("accept_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid rises (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        X = '0; Y = '0; in_tag = '0;
        #12;
        // Reset state
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_P",         P, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd0);
        chk("rst_out_tag",   {60'd0, out_tag}, 64'd0);
        @(negedge clk); #1 rst = 1'b1;
        tick();
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // 1: max operands
        out_ready = 1'b1;
        start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'hA);
        wait_done(lat);
        chk("t1_latency", 64'(lat), 64'd8);
        chk("t1_P",       P, 64'hFFFFFFFE_00000001);
        chk("t1_tag",     {60'd0, out_tag}, 64'hA);
        chk("t1_in_ready_done", {63'd0, in_ready}, 64'd1);
        tick();
        chk("t1_valid_clear", {63'd0, out_valid}, 64'd0);
        chk("t1_P_retained",  P, 64'hFFFFFFFE_00000001);

        // 2: zero and unit operands
        start_op(32'h12345678, 32'h0, 4'h1);
        wait_done(lat);
        chk("t2a_P", P, 64'd0);
        start_op(32'h0, 32'hFFFFFFFF, 4'h2);
        wait_done(lat);
        chk("t2b_P", P, 64'd0);
        start_op(32'h1, 32'h9ABCDEF0, 4'h3);
        wait_done(lat);
        chk("t2c_P", P, 64'h00000000_9ABCDEF0);
        chk("t2c_latency", 64'(lat), 64'd8);
        tick();

        // 3: backpressure with a competing request held on the input
        out_ready = 1'b0;
        start_op(32'd3, 32'd5, 4'h5);
        wait_done(lat);
        chk("t3_latency", 64'(lat), 64'd8);
        X = 32'd7; Y = 32'd9; in_tag = 4'h6; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("t3_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("t3_hold_P",     P, 64'd15);
            chk("t3_hold_ready", {63'd0, in_ready}, 64'd0);
            chk("t3_hold_tag",   {60'd0, out_tag}, 64'h5);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t3_ready_comb", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("t3_handoff_valid", {63'd0, out_valid}, 64'd0);
        wait_done(lat);
        chk("t3_next_latency", 64'(lat), 64'd8);
        chk("t3_next_P",       P, 64'd63);
        chk("t3_next_tag",     {60'd0, out_tag}, 64'h6);
        tick();

        // 4: reset in the middle of an operation
        start_op(32'h0000FFFF, 32'h0000FFFF, 4'h7);
        tick(); tick(); tick();
        #2 rst = 1'b0;
        #1;
        chk("t4_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("t4_rst_P",     P, 64'd0);
        chk("t4_rst_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk); #1 rst = 1'b1;
        tick();
        chk("t4_post_valid", {63'd0, out_valid}, 64'd0);
        start_op(32'd2, 32'd3, 4'h8);
        wait_done(lat);
        chk("t4_latency", 64'(lat), 64'd8);
        chk("t4_P",       P, 64'd6);
        chk("t4_tag",     {60'd0, out_tag}, 64'h8);
        tick();

        // 5: back-to-back random operations
        out_ready = 1'b1;
        rx = $urandom; ry = $urandom;
        exp_p = {32'd0, rx} * {32'd0, ry};
        exp_tag = 4'h0;
        start_op(rx, ry, exp_tag);
        for (int k = 0; k < 1000; k++) begin
            wait_done(lat);
            chk("t5_latency", 64'(lat), 64'd8);
            chk("t5_P",       P, exp_p);
            chk("t5_tag",     {60'd0, out_tag}, {60'd0, exp_tag});
            if (k < 999) begin
                rx = $urandom; ry = $urandom;
                X = rx; Y = ry; in_tag = 4'(k + 1); in_valid = 1'b1;
                chk("t5_ready", {63'd0, in_ready}, 64'd1);
                exp_p   = {32'd0, rx} * {32'd0, ry};
                exp_tag = 4'(k + 1);
                tick();
                in_valid = 1'b0;
            end
        end
        tick();
        chk("t5_end_valid", {63'd0, out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
